// File: rtl/gpio_pin_ctrl_pkg.sv
// gpio_pin_ctrl_pkg: shared defaults and debounce state encoding for the GPIO pin controller.
// Rev 1.0
`default_nettype none

package gpio_pin_ctrl_pkg;

   localparam int DEFAULT_NUM_PINS    = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;
   localparam int DEFAULT_DEBOUNCE_W  = 8;

   typedef enum logic [0:0] {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } debounce_state_e;

endpackage

`default_nettype wire

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: one pin's synchronizer, debounce FSM, edge detect and sticky pending flag.
// Rev 1.0 -- GPIO_PIN_CTRL_IRQ_LEVEL_EN adds level_mode (level-sensitive pending).
`default_nettype none

module gpio_pin_filter
   import gpio_pin_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_W  = DEFAULT_DEBOUNCE_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ie,
   input  logic                  cell_i,
   input  logic [DEBOUNCE_W-1:0] debounce_limit,
   input  logic                  rise_en,
   input  logic                  fall_en,
   input  logic                  clear,
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
   input  logic                  level_mode,
`endif
   output logic                  pin_value,
   output logic                  pending,
   output logic                  pending_next
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   debounce_state_e        state_q, state_d;
   logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d, cnt_eff;
   logic                   pv_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   set_pend;

   assign sync_out  = sync_q[SYNC_STAGES-1];
   // The count only carries meaning while a mismatch is being timed.
   assign cnt_eff   = (state_q == DB_COUNTING) ? cnt_q : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q    <= '0;
         state_q   <= DB_STABLE;
         cnt_q     <= '0;
         pin_value <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         pending   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], cell_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pin_value <= pv_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         pending   <= pending_next;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pv_d    = pin_value;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!ie || (sync_out == pin_value)) begin
         state_d = DB_STABLE;
         cnt_d   = '0;
      end else if (cnt_eff >= debounce_limit) begin
         state_d = DB_STABLE;
         cnt_d   = '0;
         pv_d    = sync_out;
         rise_d  = sync_out;
         fall_d  = ~sync_out;
      end else begin
         state_d = DB_COUNTING;
         cnt_d   = cnt_eff + DEBOUNCE_W'(1);
      end
   end

   always_comb begin
      set_pend = (rise_q & rise_en) | (fall_q & fall_en);
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
      if (level_mode) begin
         set_pend = (pin_value & rise_en) | (~pin_value & fall_en);
      end
`endif
      // Set has priority, so a held level condition also masks clear.
      pending_next = set_pend | (pending & ~clear);
   end

endmodule

`default_nettype wire

// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: per-pin GPIO pad controller with registered pad drive, debounced inputs and edge irqs.
// Rev 1.0 -- GPIO_PIN_CTRL_IRQ_LEVEL_EN adds the irq_level_mode port.
`default_nettype none

module gpio_pin_ctrl
   import gpio_pin_ctrl_pkg::*;
#(
   parameter int NUM_PINS    = DEFAULT_NUM_PINS,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_W  = DEFAULT_DEBOUNCE_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_PINS-1:0]   cfg_o,
   input  logic [NUM_PINS-1:0]   cfg_oe,
   input  logic [NUM_PINS-1:0]   cfg_ie,
   input  logic [DEBOUNCE_W-1:0] debounce_limit,
   input  logic [NUM_PINS-1:0]   irq_rise_en,
   input  logic [NUM_PINS-1:0]   irq_fall_en,
   input  logic [NUM_PINS-1:0]   irq_clear,
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
   input  logic [NUM_PINS-1:0]   irq_level_mode,
`endif
   input  logic [NUM_PINS-1:0]   cell_i,
   output logic [NUM_PINS-1:0]   cell_o,
   output logic [NUM_PINS-1:0]   cell_oe,
   output logic [NUM_PINS-1:0]   cell_ie,
   output logic [NUM_PINS-1:0]   pin_value,
   output logic [NUM_PINS-1:0]   irq_pending,
   output logic                  irq
);

   logic [NUM_PINS-1:0] pending_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         cell_o  <= '0;
         cell_oe <= '0;
         cell_ie <= '0;
         irq     <= 1'b0;
      end else begin
         cell_o  <= cfg_o;
         cell_oe <= cfg_oe;
         cell_ie <= cfg_ie;
         irq     <= |pending_next;
      end
   end

   // The filter sees the registered ie so input gating matches what the pad sees.
   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      gpio_pin_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_filter (
         .clock          (clock),
         .reset          (reset),
         .ie             (cell_ie[p]),
         .cell_i         (cell_i[p]),
         .debounce_limit (debounce_limit),
         .rise_en        (irq_rise_en[p]),
         .fall_en        (irq_fall_en[p]),
         .clear          (irq_clear[p]),
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
         .level_mode     (irq_level_mode[p]),
`endif
         .pin_value      (pin_value[p]),
         .pending        (irq_pending[p]),
         .pending_next   (pending_next[p])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_gpio_pin_ctrl.sv
// tb_gpio_pin_ctrl: directed + randomized bench for gpio_pin_ctrl against a run-length reference model.
// Rev 1.0
`default_nettype none

module tb_gpio_pin_ctrl;

   localparam int N  = 8;
   localparam int SS = 2;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  cfg_o = '0, cfg_oe = '0, cfg_ie = '0;
   logic [DW-1:0] debounce_limit = '0;
   logic [N-1:0]  irq_rise_en = '0, irq_fall_en = '0, irq_clear = '0;
   logic [N-1:0]  cell_i = '0;
   logic [N-1:0]  cell_o, cell_oe, cell_ie, pin_value, irq_pending;
   logic          irq;
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
   logic [N-1:0]  irq_level_mode = '0;
`endif

   int checks = 0;
   int errors = 0;

   gpio_pin_ctrl #(.NUM_PINS(N), .SYNC_STAGES(SS), .DEBOUNCE_W(DW)) dut (
      .clock          (clock),
      .reset          (reset),
      .cfg_o          (cfg_o),
      .cfg_oe         (cfg_oe),
      .cfg_ie         (cfg_ie),
      .debounce_limit (debounce_limit),
      .irq_rise_en    (irq_rise_en),
      .irq_fall_en    (irq_fall_en),
      .irq_clear      (irq_clear),
`ifdef GPIO_PIN_CTRL_IRQ_LEVEL_EN
      .irq_level_mode (irq_level_mode),
`endif
      .cell_i         (cell_i),
      .cell_o         (cell_o),
      .cell_oe        (cell_oe),
      .cell_ie        (cell_ie),
      .pin_value      (pin_value),
      .irq_pending    (irq_pending),
      .irq            (irq)
   );

   always #5 clock = ~clock;

   // Reference model: a pin accepts the synchronized level once it has
   // disagreed with pin_value for more than debounce_limit consecutive cycles.
   logic [N-1:0] m_o, m_oe, m_ie, m_pv, m_pend, m_rise, m_fall;
   logic         m_irq;
   int           m_run [N];
   bit           m_sq  [N][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit so;
      if (reset) begin
         m_o = '0; m_oe = '0; m_ie = '0; m_pv = '0; m_pend = '0;
         m_rise = '0; m_fall = '0; m_irq = 1'b0;
         for (int p = 0; p < N; p++) begin
            m_run[p] = 0;
            m_sq[p].delete();
            for (int s = 0; s < SS; s++) m_sq[p].push_back(1'b0);
         end
         return;
      end
      for (int p = 0; p < N; p++) begin
         m_pend[p] = (m_rise[p] & irq_rise_en[p]) | (m_fall[p] & irq_fall_en[p])
                   | (m_pend[p] & ~irq_clear[p]);
         m_rise[p] = 1'b0;
         m_fall[p] = 1'b0;
         so = m_sq[p].pop_front();
         m_sq[p].push_back(cell_i[p]);
         if (!m_ie[p] || so == m_pv[p]) begin
            m_run[p] = 0;
         end else begin
            m_run[p]++;
            if (m_run[p] > int'(debounce_limit)) begin
               m_pv[p]   = so;
               m_rise[p] = so;
               m_fall[p] = ~so;
               m_run[p]  = 0;
            end
         end
      end
      m_irq = |m_pend;
      m_o   = cfg_o;
      m_oe  = cfg_oe;
      m_ie  = cfg_ie;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
      check("cell_o",      cell_o,      m_o);
      check("cell_oe",     cell_oe,     m_oe);
      check("cell_ie",     cell_ie,     m_ie);
      check("pin_value",   pin_value,   m_pv);
      check("irq_pending", irq_pending, m_pend);
      check("irq",         irq,         m_irq);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check("rst_outputs", {cell_o, cell_oe, cell_ie, pin_value}, 32'h0);
      check("rst_irq", {irq_pending, irq}, 32'h0);

      // Pad drive follows cfg with one cycle latency
      reset  = 1'b0;
      cfg_oe = 8'h0F;
      cfg_o  = 8'h05;
      #1;
      check("cfg_pre_oe", cell_oe, 8'h00);
      tick();
      check("cfg_oe_lat", cell_oe, 8'h0F);
      check("cfg_o_lat",  cell_o,  8'h05);

      // Debounce latency: E + SYNC_STAGES + limit
      debounce_limit = 8'd3;
      cfg_ie = 8'hFF;
      tick();
      cell_i[0] = 1'b1;
      repeat (5) tick();
      check("lat_e4", pin_value[0], 1'b0);
      tick();
      check("lat_e5", pin_value[0], 1'b1);

      // Glitch of limit cycles is rejected
      cell_i[1] = 1'b1;
      repeat (3) tick();
      cell_i[1] = 1'b0;
      repeat (8) tick();
      check("glitch_pv",   pin_value[1], 1'b0);
      check("glitch_pend", irq_pending,  8'h00);

      // Set wins over simultaneous clear
      irq_rise_en[2] = 1'b1;
      cell_i[2] = 1'b1;
      repeat (8) tick();
      check("rise2_pend", irq_pending[2], 1'b1);
      irq_clear[2] = 1'b1;
      tick();
      irq_clear[2] = 1'b0;
      check("clr2_irq", irq, 1'b0);
      cell_i[2] = 1'b0;
      repeat (8) tick();
      cell_i[2] = 1'b1;
      repeat (6) tick();
      irq_clear[2] = 1'b1;
      tick();
      irq_clear[2] = 1'b0;
      check("setwins_pend", irq_pending[2], 1'b1);
      check("setwins_irq",  irq, 1'b1);
      irq_clear[2] = 1'b1;
      tick();
      irq_clear[2] = 1'b0;
      check("clear_alone_pend", irq_pending[2], 1'b0);
      check("clear_alone_irq",  irq, 1'b0);

      // Input disable freezes pin 3
      irq_rise_en[3] = 1'b1;
      irq_fall_en[3] = 1'b1;
      cfg_ie[3] = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         cell_i[3] = ~cell_i[3];
         tick();
      end
      cell_i[3] = 1'b1;
      repeat (4) tick();
      check("dis_pv",   pin_value[3],   1'b0);
      check("dis_pend", irq_pending[3], 1'b0);
      cfg_ie[3] = 1'b1;
      repeat (6) tick();
      check("reen_pv",   pin_value[3],   1'b1);
      check("reen_pend", irq_pending[3], 1'b1);

      // Lowering the limit mid-count takes effect on the next edge
      debounce_limit = 8'd10;
      cell_i[4] = 1'b1;
      repeat (7) tick();
      check("lim_hold", pin_value[4], 1'b0);
      debounce_limit = 8'd2;
      tick();
      check("lim_drop", pin_value[4], 1'b1);

      // Reset mid-debounce
      cell_i[5] = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_pv", pin_value, 8'h00);
      check("rst_mid_irq", irq, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < N; p++)
            if ($urandom_range(0, 5) == 0) cell_i[p] = ~cell_i[p];
         if ($urandom_range(0, 29) == 0) debounce_limit = DW'($urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) begin
            cfg_o       = N'($urandom);
            cfg_oe      = N'($urandom);
            cfg_ie      = N'($urandom | $urandom);
            irq_rise_en = N'($urandom);
            irq_fall_en = N'($urandom);
         end
         irq_clear = N'($urandom & $urandom & $urandom);
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0;
      irq_clear = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
